// File: rtl/eh2_lsu_dc_pkg.sv
// Shared definitions for the LSU data-cache controller: array op encodings,
// controller state encoding and default address/line widths.
package eh2_lsu_dc_pkg;

  localparam int unsigned DC_ADDR_W = 20;
  localparam int unsigned DC_LINE_W = 128;

  localparam logic [1:0] OP_BYTE = 2'd0;
  localparam logic [1:0] OP_WORD = 2'd1;
  localparam logic [1:0] OP_LINE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WB_REQ    = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_WAIT = 3'd4,
    S_RESP      = 3'd5
  } dc_state_e;

endpackage

// File: rtl/eh2_lsu_sat_cnt.sv
// Saturating up-counter used for the cache performance counters.
module eh2_lsu_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eh2_lsu_dc_ctl.sv
// Blocking single-request data-cache controller: lookup, dirty writeback,
// line fill with write-allocate, and hit/miss/writeback perf counters.
module eh2_lsu_dc_ctl
  import eh2_lsu_dc_pkg::*;
#(
  parameter int unsigned ADDR_W = DC_ADDR_W,
  parameter int unsigned LINE_W = DC_LINE_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_rdata,
  output logic [ADDR_W-1:0] dc_addr_tag,
  output logic [ADDR_W-1:0] dc_addr_data,
  output logic              dc_write_tag,
  output logic              dc_write_data,
  output logic [1:0]        dc_op_type_data,
  output logic [LINE_W-1:0] dc_din_tag,
  output logic [LINE_W-1:0] dc_din_data,
  input  logic [LINE_W-1:0] dc_dout_data,
  input  logic [LINE_W-1:0] dc_dout_tag,
  input  logic [ADDR_W-1:0] dc_dout_addr_tag,
  input  logic              dc_hit,
  input  logic              dc_dirty,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);

  dc_state_e         state_q, state_d;
  logic              write_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              refill_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic              op_bad;
  logic              hit_inc, miss_inc, wb_inc, dc_wr;
  logic [ADDR_W-1:0] line_addr;
  logic [31:0]       load_data;
  logic              unused_dout;

  assign op_bad    = ((op_q != OP_BYTE) && (op_q != OP_WORD)) ||
                     ((op_q == OP_WORD) && (addr_q[1:0] != 2'b00));
  assign line_addr = {addr_q[ADDR_W-1:4], 4'b0000};
  assign load_data = (op_q == OP_BYTE) ? {24'b0, dc_dout_data[7:0]} : dc_dout_data[31:0];
  assign unused_dout = ^dc_dout_data[LINE_W-1:32];

  always_comb begin
    state_d  = state_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    dc_wr    = 1'b0;
    case (state_q)
      S_IDLE:      if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (op_bad) begin
          state_d = S_RESP;
        end else if (dc_hit) begin
          state_d = S_RESP;
          hit_inc = !refill_q;
          dc_wr   = write_q;
        end else begin
          miss_inc = 1'b1;
          state_d  = dc_dirty ? S_WB_REQ : S_FILL_REQ;
        end
      end
      S_WB_REQ:    if (mem_req_ready) state_d = S_FILL_REQ;
      S_FILL_REQ:  if (mem_req_ready) state_d = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (mem_resp_valid) begin
          state_d = S_LOOKUP;
          dc_wr   = 1'b1;
        end
      end
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // refill_q marks the re-lookup after a fill so it is not counted as a hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      op_q         <= OP_BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      refill_q     <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && req_valid) begin
        write_q  <= req_write;
        op_q     <= req_op;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        refill_q <= 1'b0;
      end
      if ((state_q == S_FILL_WAIT) && mem_resp_valid) refill_q <= 1'b1;
      if (state_q == S_LOOKUP) begin
        if (op_bad) begin
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
        end else if (dc_hit) begin
          resp_err_q   <= 1'b0;
          resp_rdata_q <= write_q ? 32'd0 : load_data;
        end
      end
    end
  end

  assign wb_inc = (state_q == S_WB_REQ) && mem_req_ready;

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign resp_valid = (state_q == S_RESP) && !reset;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assign mem_req_valid = ((state_q == S_WB_REQ) || (state_q == S_FILL_REQ)) && !reset;
  assign mem_req_write = (state_q == S_WB_REQ);
  assign mem_req_addr  = (state_q == S_WB_REQ) ? dc_dout_addr_tag : line_addr;
  assign mem_req_wdata = (state_q == S_WB_REQ) ? dc_dout_tag : '0;

  assign dc_addr_tag     = (state_q == S_IDLE) ? '0 : addr_q;
  assign dc_addr_data    = (state_q == S_IDLE) ? '0 :
                           (state_q == S_FILL_WAIT) ? line_addr : addr_q;
  assign dc_op_type_data = (state_q == S_FILL_WAIT) ? OP_LINE : op_q;
  assign dc_write_tag    = 1'b0;
  assign dc_din_tag      = '0;
  assign dc_write_data   = dc_wr && !reset;
  assign dc_din_data     = (state_q == S_FILL_WAIT) ? mem_resp_rdata
                                                    : {{(LINE_W-32){1'b0}}, wdata_q};

  eh2_lsu_sat_cnt #(.W(CNT_W)) u_hit_cnt (
    .clk(clk), .reset(reset), .inc_i(hit_inc), .cnt_o(hit_cnt)
  );
  eh2_lsu_sat_cnt #(.W(CNT_W)) u_miss_cnt (
    .clk(clk), .reset(reset), .inc_i(miss_inc), .cnt_o(miss_cnt)
  );
  eh2_lsu_sat_cnt #(.W(CNT_W)) u_wb_cnt (
    .clk(clk), .reset(reset), .inc_i(wb_inc), .cnt_o(wb_cnt)
  );

endmodule
